trdb_udma_buffer: RTL and testbench
===================================

TRDB_UDMA_BUFFER -- requirements
Module: trdb_udma_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO word capacity; power of two, minimum 2.
REQ-002 SHALL have parameter CNTW, default 16, lost-word counter width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port enable_i, input, 1, accept incoming words when high.
REQ-006 SHALL have port flush_i, input, 1, synchronous clear of contents and status.
REQ-007 SHALL have port word_i, input, XLEN, packet word from the stream aligner.
REQ-008 SHALL have port word_valid_i, input, 1, word_i valid; no backpressure to the producer.
REQ-009 SHALL have port udma_data_o, output, XLEN, head-of-FIFO word.
REQ-010 SHALL have port udma_valid_o, output, 1, udma_data_o valid.
REQ-011 SHALL have port udma_ready_i, input, 1, uDMA consumes the word when high with udma_valid_o.
REQ-012 SHALL have port fill_o, output, $clog2(DEPTH)+1, current word count.
REQ-013 SHALL have ports full_o and empty_o, outputs, 1 each, fill_o==DEPTH and fill_o==0.
REQ-014 SHALL have port overflow_o, output, 1, sticky flag: at least one word dropped since reset/flush.
REQ-015 SHALL have port lost_cnt_o, output, CNTW, count of dropped words.

Function
REQ-016 SHALL push word_i when word_valid_i && enable_i && (!full_o || pop this cycle); push when full with a same-cycle pop SHALL be accepted.
REQ-017 SHALL pop when udma_valid_o && udma_ready_i; udma_valid_o = !empty_o.
REQ-018 SHALL present a pushed word on udma_data_o/udma_valid_o the cycle after the push edge (latency 1, first-word fall-through from storage).
REQ-019 SHALL hold udma_data_o stable while udma_valid_o && !udma_ready_i.
REQ-020 SHALL preserve word order; pointers wrap modulo DEPTH.
REQ-021 SHALL drop word_valid_i && enable_i words that cannot be pushed, increment lost_cnt_o saturating at 2^CNTW-1, and set overflow_o.
REQ-022 SHALL ignore words while enable_i is low, without counting them as lost.
REQ-023 SHALL give flush_i priority over push, pop and drop in the same cycle; next cycle fill_o=0, overflow_o=0, lost_cnt_o=0, and no marker pending.
REQ-024 SHALL leave udma_data_o unspecified when udma_valid_o is low.

Reset
REQ-025 SHALL, on rst_i, asynchronously set udma_valid_o=0, fill_o=0, empty_o=1, full_o=0, overflow_o=0, lost_cnt_o=0, clear the pointers and any pending marker, and drive udma_data_o='0.
REQ-026 SHALL, when reset is asserted mid-transfer, discard all buffered words; no word SHALL be presented after reset deasserts until a new push.

Configuration
REQ-027 SHALL, with TRDB_OVERFLOW_MARKER_EN defined, set marker_pending on the first drop.
REQ-028 SHALL, while marker_pending is set, drop and count every incoming word to preserve order.
REQ-029 SHALL write marker word {OVF_MARKER_TAG[15:0], lost count[15:0] (zero-extended or saturated to 16)} in the first cycle with a free slot (or same-cycle pop) and word_valid_i low.
REQ-030 SHALL, in the marker cycle, clear marker_pending and reset lost_cnt_o to 0; overflow_o SHALL stay set.
REQ-031 SHALL, without TRDB_OVERFLOW_MARKER_EN, insert no marker, accept words as soon as space frees, and leave lost_cnt_o cumulative until reset/flush.

Structure
REQ-032 SHALL take XLEN and OVF_MARKER_TAG (16'hE0F0) from trdb_pkg.
REQ-033 SHALL use one sub-module, trdb_fifo_ctrl, holding pointers, count and full/empty; storage, drop logic and marker logic SHALL stay in the top module.

Verification (DEPTH=4)
REQ-034 SHALL cover: push 0x11,0x22,0x33 with udma_ready_i=1 -> the same words in order, each one cycle after its push, fill_o never above 1.
REQ-035 SHALL cover: udma_ready_i=0, push 5 words 0xA0..0xA4 -> full_o=1 after the 4th, 0xA4 dropped, lost_cnt_o=1, overflow_o=1.
REQ-036 SHALL cover: full FIFO, push 0xB0 with udma_ready_i=1 in the same cycle -> 0xB0 accepted, fill_o stays 4, lost_cnt_o unchanged.
REQ-037 SHALL cover (macro on): after REQ-035, raise udma_ready_i, word_valid_i low -> 0xA0..0xA3 then marker 0xE0F00001, lost_cnt_o back to 0.
REQ-038 SHALL cover: flush_i with 3 words stored and push/pop the same cycle -> next cycle empty_o=1, lost_cnt_o=0, overflow_o=0.
REQ-039 SHALL cover: rst_i asserted mid-drain with 2 words stored -> udma_valid_o falls asynchronously, and only a new push produces output after deassertion.

Source files
------------

// File: rtl/trdb_pkg.sv
// trdb_pkg: shared trace-debugger widths and constants.
package trdb_pkg;
  localparam int XLEN = 32;
  localparam logic [15:0] OVF_MARKER_TAG = 16'hE0F0;
endpackage

// File: rtl/trdb_fifo_ctrl.sv
// trdb_fifo_ctrl: pointer, occupancy and full/empty bookkeeping for a power-of-two FIFO.
module trdb_fifo_ctrl #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/trdb_udma_buffer.sv
// trdb_udma_buffer: lossy trace-word FIFO towards the uDMA, counting dropped words.
// Optional TRDB_OVERFLOW_MARKER_EN inserts an overflow marker word after a loss burst.
module trdb_udma_buffer
  import trdb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNTW  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   flush_i,
  input  logic [XLEN-1:0]        word_i,
  input  logic                   word_valid_i,
  output logic [XLEN-1:0]        udma_data_o,
  output logic                   udma_valid_o,
  input  logic                   udma_ready_i,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o,
  output logic [CNTW-1:0]        lost_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [XLEN-1:0] wdata;
  logic            incoming, pop, push, drop, lost_clr;

  assign incoming     = word_valid_i && enable_i;
  assign udma_valid_o = !empty_o;
  assign pop          = udma_valid_o && udma_ready_i;
  assign udma_data_o  = empty_o ? '0 : mem[rd_ptr];

`ifdef TRDB_OVERFLOW_MARKER_EN
  localparam int LW = CNTW > 16 ? CNTW : 16;
  logic          marker_pending, marker_write;
  logic [LW-1:0] lost_ext;
  logic [15:0]   lost16;
  assign lost_ext     = LW'(lost_cnt_o);
  assign lost16       = lost_ext > LW'(16'hFFFF) ? 16'hFFFF : lost_ext[15:0];
  assign marker_write = marker_pending && !word_valid_i && (!full_o || pop);
  // Once a word is lost, everything is dropped until the marker lands, keeping order honest.
  assign push     = (incoming && !marker_pending && (!full_o || pop)) || marker_write;
  assign drop     = incoming && (marker_pending || (full_o && !pop));
  assign wdata    = marker_write ? XLEN'({OVF_MARKER_TAG, lost16}) : word_i;
  assign lost_clr = marker_write;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) marker_pending <= 1'b0;
    else marker_pending <= flush_i ? 1'b0 : drop || (marker_pending && !marker_write);
  end
`else
  assign push     = incoming && (!full_o || pop);
  assign drop     = incoming && full_o && !pop;
  assign wdata    = word_i;
  assign lost_clr = 1'b0;
`endif

  trdb_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk    (clk_i),
    .rst    (rst_i),
    .flush  (flush_i),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (fill_o),
    .full   (full_o),
    .empty  (empty_o)
  );

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
      lost_cnt_o <= '0;
    end else if (flush_i) begin
      overflow_o <= 1'b0;
      lost_cnt_o <= '0;
    end else begin
      overflow_o <= overflow_o || drop;
      lost_cnt_o <= lost_clr ? '0 : (drop && !(&lost_cnt_o)) ? lost_cnt_o + CNTW'(1) : lost_cnt_o;
    end
  end
endmodule

// File: tb/tb_trdb_udma_buffer.sv
// tb_trdb_udma_buffer: directed checks of trdb_udma_buffer at DEPTH=4 (both marker builds).
module tb_trdb_udma_buffer;
  import trdb_pkg::*;
  logic            clk = 1'b0;
  logic            rst, enable, flush, word_valid, udma_ready;
  logic [XLEN-1:0] word, udma_data;
  logic            udma_valid, full, empty, overflow;
  logic [2:0]      fill;
  logic [15:0]     lost_cnt;
  int              n_checks = 0;
  int              n_fail = 0;
  logic [15:0]     exp_lost;

  trdb_udma_buffer #(.DEPTH(4), .CNTW(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .flush_i      (flush),
    .word_i       (word),
    .word_valid_i (word_valid),
    .udma_data_o  (udma_data),
    .udma_valid_o (udma_valid),
    .udma_ready_i (udma_ready),
    .fill_o       (fill),
    .full_o       (full),
    .empty_o      (empty),
    .overflow_o   (overflow),
    .lost_cnt_o   (lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; flush = 1'b0; word = '0; word_valid = 1'b0; udma_ready = 1'b0;
    tick; tick;
    check("rst_valid", udma_valid, 0);
    check("rst_fill", fill, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_lost", lost_cnt, 0);
    check("rst_data", udma_data, 0);
    rst = 1'b0;
    tick;

    // streaming: each word appears one cycle after its push, fill never exceeds 1
    udma_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      word = 32'h11 * (i + 1); word_valid = 1'b1;
      tick;
      check("stream_valid", udma_valid, 1);
      check("stream_data", udma_data, 32'h11 * (i + 1));
      check("stream_fill", fill, 1);
    end
    word_valid = 1'b0;
    tick;
    check("stream_empty", empty, 1);

    // fill to full with no consumer, fifth word is lost
    udma_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      word = 32'hA0 + i; word_valid = 1'b1;
      tick;
      if (i == 3) begin
        check("ovf_full", full, 1);
        check("ovf_fill4", fill, 4);
        check("ovf_noloss_yet", lost_cnt, 0);
      end
    end
    word_valid = 1'b0;
    check("ovf_lost", lost_cnt, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_fill", fill, 4);
    check("ovf_head", udma_data, 32'hA0);

    udma_ready = 1'b1;
`ifdef TRDB_OVERFLOW_MARKER_EN
    for (int i = 0; i < 5; i++) begin
      check("mk_data", udma_data, i < 4 ? 32'hA0 + i : 32'hE0F00001);
      tick;
      if (i == 0) begin
        check("mk_lost_clr", lost_cnt, 0);
        check("mk_ovf_kept", overflow, 1);
      end
    end
    check("mk_empty", empty, 1);
    exp_lost = 16'd0;
`else
    for (int i = 0; i < 4; i++) begin
      check("drain_data", udma_data, 32'hA0 + i);
      tick;
    end
    check("drain_empty", empty, 1);
    check("drain_lost_kept", lost_cnt, 1);
    check("drain_ovf_kept", overflow, 1);
    exp_lost = 16'd1;
`endif

    // push into a full FIFO while it is being popped
    udma_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      word = 32'hC0 + i; word_valid = 1'b1;
      tick;
    end
    check("fp_full", full, 1);
    udma_ready = 1'b1; word = 32'hB0; word_valid = 1'b1;
    tick;
    word_valid = 1'b0;
    check("fp_fill", fill, 4);
    check("fp_lost", lost_cnt, exp_lost);
    for (int i = 0; i < 4; i++) begin
      check("fp_data", udma_data, i < 3 ? 32'hC1 + i : 32'hB0);
      tick;
    end
    check("fp_empty", empty, 1);

    // flush wins over simultaneous push/pop and clears the loss status
    udma_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      word = 32'hD0 + i; word_valid = 1'b1;
      tick;
    end
    check("fl_pre_ovf", overflow, 1);
    flush = 1'b1; udma_ready = 1'b1; word = 32'hD5; word_valid = 1'b1;
    tick;
    flush = 1'b0; word_valid = 1'b0;
    check("fl_empty", empty, 1);
    check("fl_fill", fill, 0);
    check("fl_lost", lost_cnt, 0);
    check("fl_ovf", overflow, 0);
    check("fl_valid", udma_valid, 0);
    tick;
    check("fl_no_marker", empty, 1);

    // disabled input is ignored, not counted as lost
    enable = 1'b0; word = 32'h99; word_valid = 1'b1;
    tick;
    check("dis_empty", empty, 1);
    check("dis_lost", lost_cnt, 0);
    enable = 1'b1; word_valid = 1'b0;

    // asynchronous reset mid-drain
    udma_ready = 1'b0;
    word = 32'hE0; word_valid = 1'b1; tick;
    word = 32'hE1; tick;
    word_valid = 1'b0; udma_ready = 1'b1;
    check("ar_head", udma_data, 32'hE0);
    check("ar_fill", fill, 2);
    #2 rst = 1'b1;
    #1;
    check("ar_async_valid", udma_valid, 0);
    check("ar_async_fill", fill, 0);
    tick;
    rst = 1'b0;
    tick;
    check("ar_post_valid", udma_valid, 0);
    check("ar_post_empty", empty, 1);
    word = 32'hF0; word_valid = 1'b1;
    tick;
    word_valid = 1'b0;
    check("ar_new_valid", udma_valid, 1);
    check("ar_new_data", udma_data, 32'hF0);
    tick;
    check("ar_new_drained", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
